// File: rtl/game_pkg.sv
// Shared game definitions: STATE codes, RESULT encodings, judge FSM states, widths.
package game_pkg;
    localparam int DIGIT_W       = 4;
    localparam int PROD_W        = 10;
    localparam int WIN_SCORE_DEF = 3;
    localparam int MAX_MISS_DEF  = 3;

    localparam logic [3:0] ST_INPUT = 4'b0100;
    localparam logic [3:0] ST_CLR0  = 4'b0110;   // DRAW
    localparam logic [3:0] ST_CLR1  = 4'b1000;   // OUCH
    localparam logic [3:0] ST_CLR2  = 4'b1001;   // GOOD
    localparam logic [3:0] ST_CLR3  = 4'b1010;   // WIN
    localparam logic [3:0] ST_CLR4  = 4'b1011;   // LOSE

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_GOOD = 2'b01;
    localparam logic [1:0] RES_OUCH = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_CHECK, S_MUL_A, S_MUL_B, S_VERDICT
    } judge_state_t;

    function automatic logic is_clr_state(input logic [3:0] s);
        return s inside {ST_CLR0, ST_CLR1, ST_CLR2, ST_CLR3, ST_CLR4};
    endfunction

    function automatic logic bad_nibble(input logic [3:0] d);
        return d > 4'd9;
    endfunction
endpackage

// File: rtl/shift_add_mul.sv
// Serial shift-add multiplier: W-bit multiplicand x 4-bit multiplier, one
// multiplier bit per cycle (LSB first); the start cycle is the first step.
module shift_add_mul import game_pkg::*; #(
    parameter int W = PROD_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               abort,
    input  logic [W-1:0]       mcand,
    input  logic [DIGIT_W-1:0] mplier,
    output logic [W-1:0]       product,
    output logic               running,
    output logic               done
);
    logic [1:0]   bidx;
    logic [1:0]   sel;
    logic [W-1:0] addend;

    assign sel    = start ? 2'd0 : bidx;
    assign addend = mplier[sel] ? (mcand << sel) : '0;
    assign done   = running && (bidx == 2'd3);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            product <= '0;
            bidx    <= '0;
            running <= 1'b0;
        end else if (start) begin
            product <= addend;
            bidx    <= 2'd1;
            running <= 1'b1;
        end else if (abort) begin
            running <= 1'b0;
        end else if (running) begin
            product <= product + addend;
            bidx    <= bidx + 2'd1;
            if (bidx == 2'd3) running <= 1'b0;
        end
    end
endmodule

// File: rtl/answer_judge.sv
// Multiplies the three factor digits, compares with the BCD question and keeps
// hit/miss tallies. Define PRODUCT_BCD_EN to get the sequential BCD product.
module answer_judge import game_pkg::*; #(
    parameter int WIN_SCORE = WIN_SCORE_DEF,
    parameter int MAX_MISS  = MAX_MISS_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [3:0]    STATE,
    input  logic          DEC,
    input  logic [11:0]   QUE_BCD,
    input  logic [3:0]    COUNT1_IN,
    input  logic [3:0]    COUNT2_IN,
    input  logic [3:0]    COUNT3_IN,
    output logic          BUSY,
    output logic          JUDGE_DONE,
    output logic [1:0]    RESULT,
    output logic [9:0]    PRODUCT,
    output logic [3:0]    HIT_CNT,
    output logic [3:0]    MISS_CNT,
    output logic          WIN_REQ,
    output logic          LOSE_REQ,
    output logic [11:0]   PRODUCT_BCD
);
    judge_state_t state, state_nxt;
    logic         dec_q, dec_qq;
    logic [3:0]   c1, c2, c3;
    logic [11:0]  que_q;
    logic         start_a, start_b, run_a, run_b, done_a, done_b;
    logic [9:0]   prod_a, prod_b, qbin, prod_final;
    logic         bad, good, clr, clr_tally, abort;

    assign clr       = is_clr_state(STATE);
    assign clr_tally = (STATE == ST_CLR3) || (STATE == ST_CLR4);
    assign abort     = clr && (state != S_IDLE);
    assign BUSY      = (state != S_IDLE);
    assign WIN_REQ   = (HIT_CNT >= 4'(WIN_SCORE));
    assign LOSE_REQ  = (MISS_CNT >= 4'(MAX_MISS)) && !WIN_REQ;

    assign bad = (c1 == 4'd0) || (c2 == 4'd0) || (c3 == 4'd0) ||
                 bad_nibble(c1) || bad_nibble(c2) || bad_nibble(c3) ||
                 bad_nibble(que_q[11:8]) || bad_nibble(que_q[7:4]) || bad_nibble(que_q[3:0]);
    assign qbin = {6'd0, que_q[11:8]} * 10'd100 + {6'd0, que_q[7:4]} * 10'd10 + {6'd0, que_q[3:0]};
    assign prod_final = bad ? 10'd0 : prod_b;
    assign good       = !bad && (prod_b == qbin);

    shift_add_mul #(.W(PROD_W)) u_mul_a (
        .CLK(CLK), .RST(RST), .start(start_a), .abort(abort),
        .mcand({{(PROD_W-DIGIT_W){1'b0}}, c1}), .mplier(c2),
        .product(prod_a), .running(run_a), .done(done_a)
    );

    shift_add_mul #(.W(PROD_W)) u_mul_b (
        .CLK(CLK), .RST(RST), .start(start_b), .abort(abort),
        .mcand(prod_a), .mplier(c3),
        .product(prod_b), .running(run_b), .done(done_b)
    );

    always_comb begin
        state_nxt = state;
        start_a   = 1'b0;
        start_b   = 1'b0;
        case (state)
            S_IDLE:    if (STATE == ST_INPUT && dec_q && !dec_qq && QUE_BCD != 12'd0)
                           state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_CHECK;
            S_CHECK:   state_nxt = bad ? S_VERDICT : S_MUL_A;
            S_MUL_A: begin
                start_a = !run_a;
                if (done_a) state_nxt = S_MUL_B;
            end
            S_MUL_B: begin
                start_b = !run_b;
                if (done_b) state_nxt = S_VERDICT;
            end
            S_VERDICT: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        // A clear-state while busy drops the judge without reporting.
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            dec_q      <= 1'b0;
            dec_qq     <= 1'b0;
            c1         <= '0;
            c2         <= '0;
            c3         <= '0;
            que_q      <= '0;
            JUDGE_DONE <= 1'b0;
            RESULT     <= RES_NONE;
            PRODUCT    <= '0;
            HIT_CNT    <= '0;
            MISS_CNT   <= '0;
        end else begin
            state      <= state_nxt;
            dec_q      <= DEC;
            dec_qq     <= dec_q;
            JUDGE_DONE <= 1'b0;
            if (state == S_CAPTURE) begin
                c1    <= COUNT1_IN;
                c2    <= COUNT2_IN;
                c3    <= COUNT3_IN;
                que_q <= QUE_BCD;
            end
            if (clr) begin
                RESULT  <= RES_NONE;
                PRODUCT <= '0;
                if (clr_tally) begin
                    HIT_CNT  <= '0;
                    MISS_CNT <= '0;
                end
            end else if (state == S_VERDICT) begin
                JUDGE_DONE <= 1'b1;
                RESULT     <= good ? RES_GOOD : RES_OUCH;
                PRODUCT    <= prod_final;
                if (good && HIT_CNT != 4'hF)   HIT_CNT  <= HIT_CNT + 4'd1;
                if (!good && MISS_CNT != 4'hF) MISS_CNT <= MISS_CNT + 4'd1;
            end
        end
    end

`ifdef PRODUCT_BCD_EN
    logic [9:0]  dd_bin;
    logic [11:0] dd_bcd, dd_adj, bcd_q;
    logic [3:0]  dd_cnt;
    logic        dd_run;

    always_comb begin
        dd_adj = dd_bcd;
        for (int i = 0; i < 3; i++)
            if (dd_bcd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd_bcd[4*i +: 4] + 4'd3;
    end

    // Double-dabble: adjust then shift, one product bit per cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dd_bin <= '0;
            dd_bcd <= '0;
            dd_cnt <= '0;
            dd_run <= 1'b0;
            bcd_q  <= '0;
        end else if (clr) begin
            dd_run <= 1'b0;
            bcd_q  <= '0;
        end else if (state == S_VERDICT) begin
            dd_bin <= prod_final;
            dd_bcd <= '0;
            dd_cnt <= '0;
            dd_run <= 1'b1;
        end else if (dd_run) begin
            {dd_bcd, dd_bin} <= {dd_adj[10:0], dd_bin, 1'b0};
            dd_cnt <= dd_cnt + 4'd1;
            if (dd_cnt == 4'd9) begin
                bcd_q  <= {dd_adj[10:0], dd_bin[9]};
                dd_run <= 1'b0;
            end
        end
    end

    assign PRODUCT_BCD = bcd_q;
`else
    assign PRODUCT_BCD = '0;
`endif
endmodule

// File: tb/tb_answer_judge.sv
// Scoreboard bench for answer_judge: stimulus pushes model expectations, a
// negedge monitor pops and compares on every JUDGE_DONE.
module tb_answer_judge;
    import game_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  STATE = ST_INPUT;
    logic        DEC = 1'b0;
    logic [11:0] QUE_BCD = '0;
    logic [3:0]  COUNT1_IN = '0, COUNT2_IN = '0, COUNT3_IN = '0;
    logic        BUSY, JUDGE_DONE, WIN_REQ, LOSE_REQ;
    logic [1:0]  RESULT;
    logic [9:0]  PRODUCT;
    logic [3:0]  HIT_CNT, MISS_CNT;
    logic [11:0] PRODUCT_BCD;

    answer_judge dut (
        .CLK(CLK), .RST(RST), .STATE(STATE), .DEC(DEC), .QUE_BCD(QUE_BCD),
        .COUNT1_IN(COUNT1_IN), .COUNT2_IN(COUNT2_IN), .COUNT3_IN(COUNT3_IN),
        .BUSY(BUSY), .JUDGE_DONE(JUDGE_DONE), .RESULT(RESULT), .PRODUCT(PRODUCT),
        .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT), .WIN_REQ(WIN_REQ), .LOSE_REQ(LOSE_REQ),
        .PRODUCT_BCD(PRODUCT_BCD)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int res, prod, hit, miss, win, lose, done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_fail = 0;
    int   m_hit = 0, m_miss = 0, m_prod = 0, last_done = 0;
    logic [3:0] clr_codes[5] = '{ST_CLR0, ST_CLR1, ST_CLR2, ST_CLR3, ST_CLR4};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int p);
        return 12'(((p / 100) % 10) * 256 + ((p / 10) % 10) * 16 + p % 10);
    endfunction

    // Reference: plain arithmetic on the game rules.
    task automatic model_push(input logic [3:0] a, b, c, input logic [11:0] q, input int start_cyc);
        exp_t e;
        bit bad, good;
        int p, qb;
        bad = (a == 0) || (b == 0) || (c == 0) || (a > 9) || (b > 9) || (c > 9) ||
              (q[11:8] > 9) || (q[7:4] > 9) || (q[3:0] > 9);
        p  = int'(a) * int'(b) * int'(c);
        qb = int'(q[11:8]) * 100 + int'(q[7:4]) * 10 + int'(q[3:0]);
        good = !bad && (p == qb);
        if (good && m_hit < 15) m_hit++;
        if (!good && m_miss < 15) m_miss++;
        m_prod     = bad ? 0 : p;
        e.res      = good ? 1 : 2;
        e.prod     = m_prod;
        e.hit      = m_hit;
        e.miss     = m_miss;
        e.win      = (m_hit >= 3) ? 1 : 0;
        e.lose     = (m_miss >= 3 && m_hit < 3) ? 1 : 0;
        e.done_cyc = start_cyc + 2 + (bad ? 3 : 11);
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST && JUDGE_DONE) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("result",  int'(RESULT),   e.res);
                chk("product", int'(PRODUCT),  e.prod);
                chk("hit_cnt", int'(HIT_CNT),  e.hit);
                chk("miss_cnt", int'(MISS_CNT), e.miss);
                chk("win_req", int'(WIN_REQ),  e.win);
                chk("lose_req", int'(LOSE_REQ), e.lose);
                chk("latency", cyc, e.done_cyc);
                last_done = cyc;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: %0d verdicts pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_bcd();
        while (cyc < last_done + 10) @(negedge CLK);
`ifdef PRODUCT_BCD_EN
        chk("product_bcd", int'(PRODUCT_BCD), int'(to_bcd(m_prod)));
`else
        chk("product_bcd", int'(PRODUCT_BCD), 0);
`endif
    endtask

    task automatic launch(input logic [3:0] a, b, c, input logic [11:0] q, input bit expect_it);
        @(negedge CLK);
        STATE = ST_INPUT;
        COUNT1_IN = a; COUNT2_IN = b; COUNT3_IN = c; QUE_BCD = q;
        DEC = 1'b1;
        if (expect_it) model_push(a, b, c, q, cyc);
    endtask

    task automatic job(input logic [3:0] a, b, c, input logic [11:0] q, input bit do_bcd);
        launch(a, b, c, q, 1'b1);
        @(negedge CLK);
        DEC = 1'b0;
        wait_idle();
        if (do_bcd) check_bcd();
    endtask

    task automatic clear(input logic [3:0] code);
        @(negedge CLK);
        STATE = code;
        @(negedge CLK);
        STATE = ST_INPUT;
        if (code == ST_CLR3 || code == ST_CLR4) begin
            m_hit  = 0;
            m_miss = 0;
        end
        m_prod = 0;
        chk("clr_result", int'(RESULT), 0);
        chk("clr_product", int'(PRODUCT), 0);
        chk("clr_bcd", int'(PRODUCT_BCD), 0);
        chk("clr_hit", int'(HIT_CNT), m_hit);
        chk("clr_miss", int'(MISS_CNT), m_miss);
        chk("clr_win", int'(WIN_REQ), (m_hit >= 3) ? 1 : 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(BUSY), 0);
        chk({tag, "_done"}, int'(JUDGE_DONE), 0);
        chk({tag, "_result"}, int'(RESULT), 0);
        chk({tag, "_product"}, int'(PRODUCT), 0);
        chk({tag, "_hit"}, int'(HIT_CNT), 0);
        chk({tag, "_miss"}, int'(MISS_CNT), 0);
        chk({tag, "_win"}, int'(WIN_REQ), 0);
        chk({tag, "_lose"}, int'(LOSE_REQ), 0);
        chk({tag, "_bcd"}, int'(PRODUCT_BCD), 0);
    endtask

    initial begin
        logic [3:0]  a, b, c;
        logic [11:0] q;
        int p;

        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b0;

        job(4'd2, 4'd3, 4'd5, 12'h030, 1'b1);
        job(4'd9, 4'd9, 4'd9, 12'h729, 1'b1);
        job(4'd9, 4'd9, 4'd9, 12'h728, 1'b0);
        job(4'd1, 4'd0, 4'd3, 12'h012, 1'b1);
        job(4'd1, 4'd2, 4'd3, 12'h0A5, 1'b0);

        // DEC held high: exactly one verdict.
        launch(4'd1, 4'd1, 4'd1, 12'h001, 1'b1);
        repeat (20) @(negedge CLK);
        DEC = 1'b0;
        wait_idle();
        repeat (15) @(negedge CLK);

        clear(ST_CLR3);
        job(4'd4, 4'd5, 4'd6, 12'h120, 1'b1);
        job(4'd1, 4'd1, 4'd7, 12'h007, 1'b0);
        job(4'd3, 4'd3, 4'd3, 12'h027, 1'b0);

        // Second DEC edge while busy is ignored.
        launch(4'd2, 4'd2, 4'd2, 12'h008, 1'b1);
        @(negedge CLK);
        DEC = 1'b0;
        repeat (4) @(negedge CLK);
        DEC = 1'b1;
        @(negedge CLK);
        DEC = 1'b0;
        wait_idle();
        repeat (15) @(negedge CLK);

        clear(ST_CLR4);
        job(4'd2, 4'd2, 4'd2, 12'h009, 1'b0);

        // Clear-state during MUL_A aborts silently.
        launch(4'd3, 4'd3, 4'd3, 12'h027, 1'b0);
        @(negedge CLK);
        DEC = 1'b0;
        repeat (4) @(negedge CLK);
        STATE = ST_CLR1;
        @(negedge CLK);
        STATE = ST_INPUT;
        repeat (20) @(negedge CLK);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_result", int'(RESULT), 0);
        chk("abort_hit", int'(HIT_CNT), m_hit);
        chk("abort_miss", int'(MISS_CNT), m_miss);

        for (int k = 0; k < 30; k++) begin
            a = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(1, 9));
            b = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(1, 9));
            c = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(1, 9));
            p = int'(a) * int'(b) * int'(c);
            if ($urandom_range(1) == 1) q = to_bcd(p);
            else q = {4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
            if ($urandom_range(7) == 0) q[3:0] = 4'($urandom_range(10, 15));
            if (q == 12'd0) q = 12'h001;
            job(a, b, c, q, k < 6);
            if ($urandom_range(5) == 0) clear(clr_codes[$urandom_range(4)]);
        end

        // Reset in the middle of MUL_B.
        launch(4'd7, 4'd8, 4'd9, 12'h504, 1'b0);
        @(negedge CLK);
        DEC = 1'b0;
        repeat (8) @(negedge CLK);
        RST = 1'b1;
        #1;
        check_all_zero("midreset");
        m_hit  = 0;
        m_miss = 0;
        m_prod = 0;
        @(negedge CLK);
        RST = 1'b0;
        job(4'd7, 4'd8, 4'd9, 12'h504, 1'b1);

        repeat (5) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
